encoder_8b10b_rd: RTL and testbench
===================================

ENCODER_8B10B_RD -- requirements
Module: encoder_8b10b_rd

Interface
REQ-001 SHALL provide parameter LANES, default 1, meaning the number of bytes encoded per pclk cycle; legal values are 1, 2 and 4.
REQ-002 SHALL provide port pclk  input  1  sole clock, rising-edge active.
REQ-003 SHALL provide port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port data_in  input  8*LANES  byte per lane; lane n occupies [8n+7:8n]; HGF EDCBA with A at bit 0.
REQ-005 SHALL provide port data_k  input  LANES  per-lane flag, 1 = control (K) symbol, 0 = data (D) symbol.
REQ-006 SHALL provide port data_valid  input  1  qualifies data_in/data_k this cycle.
REQ-007 SHALL provide port rd_set  input  1  load running disparity (RD) from rd_set_val this cycle.
REQ-008 SHALL provide port rd_set_val  input  1  RD to load, 0 = RD-, 1 = RD+.
REQ-009 SHALL provide port encoded_data  output  10*LANES  symbol per lane; lane n occupies [10n+9:10n]; abcdei at [9:4], fghj at [3:0], a at bit 9.
REQ-010 SHALL provide port enc_valid  output  1  encoded_data holds a new symbol group.
REQ-011 SHALL provide port rd_out  output  1  RD after the last symbol of the most recent group.
REQ-012 SHALL provide port code_err  output  LANES  per-lane flag, illegal K code requested.

Function
REQ-013 SHALL encode per IEEE 802.3 Clause 36 8b/10b tables: 5b/6b on EDCBA and 3b/4b on HGF, with the sub-block selected by the current RD.
REQ-014 SHALL track RD across sub-blocks: the 6b sub-block uses the incoming RD; the 4b sub-block uses the RD after the 6b sub-block; a non-neutral sub-block flips RD.
REQ-015 SHALL use the alternate D.x.A7 encoding (0111 at RD-, 1000 at RD+) for x=17,18,20 at RD- and for x=11,13,14 at RD+; all other D.x.7 SHALL use P7.
REQ-016 SHALL accept only K28.0-K28.7, K23.7, K27.7, K29.7 and K30.7 as K codes.
REQ-017 SHALL, for any other K request, emit K28.5 in that lane at the current RD, update RD as for K28.5, and assert code_err[n].
REQ-018 SHALL chain RD within a cycle: lane 0 encodes first using the registered RD, and lane n uses the RD after lane n-1.
REQ-019 SHALL register the RD leaving the last lane, and present it on rd_out.
REQ-020 SHALL register outputs with a latency of 1 cycle: inputs sampled at edge k appear on encoded_data/enc_valid/code_err after edge k.
REQ-021 SHALL, when data_valid=0, deassert enc_valid and clear code_err, hold encoded_data, and leave RD unchanged.
REQ-022 SHALL, when rd_set=1, apply rd_set_val before encoding; with data_valid=1 in the same cycle, lane 0 SHALL use rd_set_val.
REQ-023 SHALL, when rd_set=1 and data_valid=0, register rd_set_val as RD and drive rd_out=rd_set_val after the edge.

Reset
REQ-024 SHALL, while rst=0, asynchronously force encoded_data=0, enc_valid=0, code_err=0, rd_out=0, and internal RD=RD-.
REQ-025 SHALL, on rst deassertion mid-stream, discard any input presented during reset; the first valid group after release SHALL encode from RD-.

Verification
REQ-026 SHALL cover reset: assert rst=0 mid-stream -> encoded_data=0, enc_valid=0, rd_out=0 immediately, without waiting for a clock edge.
REQ-027 SHALL cover LANES=1 from RD- with D0.0 (8'h00, k=0) -> 10'b100111_0100, rd_out=0; then D3.0 (8'h03) -> 10'b110001_1011, rd_out=1.
REQ-028 SHALL cover K28.5 (8'hBC, k=1): at RD- -> 10'b001111_1010, rd_out=1; next cycle K28.5 again -> 10'b110000_0101, rd_out=0.
REQ-029 SHALL cover alternate encoding: D17.7 (8'hF1) at RD- -> 10'b100011_0111; then illegal K (8'h00, k=1) -> K28.5 symbol and code_err=1.
REQ-030 SHALL cover LANES=2 from RD-: data_in=16'h0303, data_k=0 -> lane0 10'b110001_1011, lane1 10'b110001_0100, rd_out=0.
REQ-031 SHALL cover rd_set=1, rd_set_val=1 with data_valid=1 and D0.0 -> 10'b011000_1011, rd_out=1; data_valid=0 cycles -> enc_valid=0, encoded_data and rd_out held.

Source files
------------

// File: rtl/encoder_8b10b_rd.sv
// encoder_8b10b_rd: 8b/10b encoder, LANES bytes per cycle, running disparity chained lane to lane.
module encoder_8b10b_rd #(
  parameter int LANES = 1
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [8*LANES-1:0]  data_in,
  input  logic [LANES-1:0]    data_k,
  input  logic                data_valid,
  input  logic                rd_set,
  input  logic                rd_set_val,
  output logic [10*LANES-1:0] encoded_data,
  output logic                enc_valid,
  output logic                rd_out,
  output logic [LANES-1:0]    code_err
);
  logic [10*LANES-1:0] sym_q, sym_d;
  logic [LANES-1:0]    err_q, err_d;
  logic                vld_q, rd_q, rd_d;

  // Returns {abcdei, fghj, rd after symbol, illegal K}; tables hold the RD- form, RD+ is the complement
  function automatic logic [11:0] enc(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic       ok, nn6, nn4, r6, a7;
    logic [5:0] c6;
    logic [3:0] c4;
    ok = !k || b[4:0] == 5'd28 || b inside {8'hF7, 8'hFB, 8'hFD, 8'hFE};
    {y, x} = ok ? b : 8'hBC;
    case (x)
      5'd0:  c6 = 6'b100111;
      5'd1:  c6 = 6'b011101;
      5'd2:  c6 = 6'b101101;
      5'd3:  c6 = 6'b110001;
      5'd4:  c6 = 6'b110101;
      5'd5:  c6 = 6'b101001;
      5'd6:  c6 = 6'b011001;
      5'd7:  c6 = 6'b111000;
      5'd8:  c6 = 6'b111001;
      5'd9:  c6 = 6'b100101;
      5'd10: c6 = 6'b010101;
      5'd11: c6 = 6'b110100;
      5'd12: c6 = 6'b001101;
      5'd13: c6 = 6'b101100;
      5'd14: c6 = 6'b011100;
      5'd15: c6 = 6'b010111;
      5'd16: c6 = 6'b011011;
      5'd17: c6 = 6'b100011;
      5'd18: c6 = 6'b010011;
      5'd19: c6 = 6'b110010;
      5'd20: c6 = 6'b001011;
      5'd21: c6 = 6'b101010;
      5'd22: c6 = 6'b011010;
      5'd23: c6 = 6'b111010;
      5'd24: c6 = 6'b110011;
      5'd25: c6 = 6'b100110;
      5'd26: c6 = 6'b010110;
      5'd27: c6 = 6'b110110;
      5'd28: c6 = k ? 6'b001111 : 6'b001110;
      5'd29: c6 = 6'b101110;
      5'd30: c6 = 6'b011110;
      default: c6 = 6'b101011;
    endcase
    nn6 = $countones(c6) != 3;
    r6  = rd ^ nn6;
    // D.7 is neutral yet still has distinct RD-/RD+ forms
    c6  = (rd && (nn6 || x == 5'd7)) ? ~c6 : c6;
    a7  = !k && y == 3'd7 && (r6 ? x inside {5'd11, 5'd13, 5'd14} : x inside {5'd17, 5'd18, 5'd20});
    case (y)
      3'd0:    c4 = 4'b1011;
      3'd1:    c4 = k ? 4'b0110 : 4'b1001;
      3'd2:    c4 = k ? 4'b1010 : 4'b0101;
      3'd3:    c4 = 4'b1100;
      3'd4:    c4 = 4'b1101;
      3'd5:    c4 = k ? 4'b0101 : 4'b1010;
      3'd6:    c4 = k ? 4'b1001 : 4'b0110;
      default: c4 = (k || a7) ? 4'b0111 : 4'b1110;
    endcase
    nn4 = $countones(c4) != 2;
    c4  = (r6 && (k || nn4 || y == 3'd3)) ? ~c4 : c4;
    return {c6, c4, r6 ^ nn4, !ok};
  endfunction

  always_comb begin : encode
    logic        rd_c;
    logic [11:0] r;
    rd_c  = rd_set ? rd_set_val : rd_q;
    sym_d = sym_q;
    err_d = '0;
    for (int n = 0; n < LANES; n++) begin
      r = enc(data_in[8*n +: 8], data_k[n], rd_c);
      if (data_valid) begin
        sym_d[10*n +: 10] = r[11:2];
        err_d[n]          = r[0];
        rd_c              = r[1];
      end
    end
    rd_d = rd_c;
  end

  always_ff @(posedge pclk or negedge rst)
    if (!rst) begin
      sym_q <= '0;
      err_q <= '0;
      vld_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      sym_q <= sym_d;
      err_q <= err_d;
      vld_q <= data_valid;
      rd_q  <= rd_d;
    end

  assign encoded_data = sym_q;
  assign code_err     = err_q;
  assign enc_valid    = vld_q;
  assign rd_out       = rd_q;
endmodule

// File: tb/tb_encoder_8b10b_rd.sv
// tb_encoder_8b10b_rd: directed scoreboard checks plus exhaustive disparity/uniqueness sweeps.
module tb_encoder_8b10b_rd;
  logic pclk = 1'b0, rst = 1'b0;
  always #5 pclk = ~pclk;

  logic [7:0]  d1 = '0;
  logic        k1 = 1'b0, v1 = 1'b0, rs1 = 1'b0, rv1 = 1'b0;
  logic [9:0]  e1;
  logic        ev1, ro1, ce1;
  logic [15:0] d2 = '0;
  logic [1:0]  k2 = '0;
  logic        v2 = 1'b0, rs2 = 1'b0, rv2 = 1'b0;
  logic [19:0] e2;
  logic        ev2, ro2;
  logic [1:0]  ce2;

  encoder_8b10b_rd #(.LANES(1)) dut1 (
    .pclk(pclk), .rst(rst), .data_in(d1), .data_k(k1), .data_valid(v1),
    .rd_set(rs1), .rd_set_val(rv1), .encoded_data(e1), .enc_valid(ev1),
    .rd_out(ro1), .code_err(ce1)
  );

  encoder_8b10b_rd #(.LANES(2)) dut2 (
    .pclk(pclk), .rst(rst), .data_in(d2), .data_k(k2), .data_valid(v2),
    .rd_set(rs2), .rd_set_val(rv2), .encoded_data(e2), .enc_valid(ev2),
    .rd_out(ro2), .code_err(ce2)
  );

  typedef struct packed {
    logic [9:0] sym;
    logic       vld;
    logic       err;
    logic       rd;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0;
  logic [9:0] seen [2][256];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic k, input logic v, input logic rs, input logic rv);
    @(negedge pclk);
    d1 = d; k1 = k; v1 = v; rs1 = rs; rv1 = rv;
    @(posedge pclk);
    #1;
  endtask

  task automatic step(input string tag, input logic [7:0] d, input logic k, input logic v,
                      input logic rs, input logic rv, input exp_t e);
    exp_t x;
    sb.push_back(e);
    drive(d, k, v, rs, rv);
    x = sb.pop_front();
    chk({tag, ".sym"}, e1, x.sym);
    chk({tag, ".vld"}, ev1, x.vld);
    chk({tag, ".err"}, ce1, x.err);
    chk({tag, ".rd"}, ro1, x.rd);
  endtask

  // Each sub-block must be balanced or lean against the incoming RD, and rd_out must follow
  task automatic check_disp(input string tag, input logic rd);
    int   c6, c4;
    logic r6, ok;
    c6 = $countones(e1[9:4]);
    c4 = $countones(e1[3:0]);
    ok = rd ? (c6 == 2 || c6 == 3) : (c6 == 3 || c6 == 4);
    r6 = rd ? (c6 != 2) : (c6 == 4);
    ok = ok && (r6 ? (c4 == 1 || c4 == 2) : (c4 == 2 || c4 == 3));
    chk({tag, ".disp"}, ok, 1);
    chk({tag, ".rd"}, ro1, r6 ? (c4 != 1) : (c4 == 3));
  endtask

  initial begin
    int   dups;
    logic legal;
    #1;
    chk("rst.sym", e1, 0);
    chk("rst.vld", ev1, 0);
    chk("rst.err", ce1, 0);
    chk("rst.rd", ro1, 0);
    repeat (2) @(negedge pclk);
    rst = 1'b1;

    step("D0.0", 8'h00, 0, 1, 0, 0, '{10'b100111_0100, 1, 0, 0});
    step("D3.0", 8'h03, 0, 1, 0, 0, '{10'b110001_1011, 1, 0, 1});
    step("D3.0p", 8'h03, 0, 1, 0, 0, '{10'b110001_0100, 1, 0, 0});
    step("K28.5m", 8'hBC, 1, 1, 0, 0, '{10'b001111_1010, 1, 0, 1});
    step("K28.5p", 8'hBC, 1, 1, 0, 0, '{10'b110000_0101, 1, 0, 0});
    step("D17.7A", 8'hF1, 0, 1, 0, 0, '{10'b100011_0111, 1, 0, 1});
    step("badK", 8'h00, 1, 1, 0, 0, '{10'b110000_0101, 1, 1, 0});
    step("idle", 8'h55, 0, 0, 0, 0, '{10'b110000_0101, 0, 0, 0});
    step("rdset", 8'h00, 0, 1, 1, 1, '{10'b011000_1011, 1, 0, 1});
    step("hold1", 8'h03, 0, 0, 0, 0, '{10'b011000_1011, 0, 0, 1});
    step("hold2", 8'hBC, 1, 0, 0, 0, '{10'b011000_1011, 0, 0, 1});
    step("rdset0", 8'h00, 0, 0, 1, 0, '{10'b011000_1011, 0, 0, 0});
    step("D21.5", 8'hB5, 0, 1, 0, 0, '{10'b101010_1010, 1, 0, 0});
    step("K28.7", 8'hFC, 1, 1, 0, 0, '{10'b001111_1000, 1, 0, 0});
    step("D11.7m", 8'hEB, 0, 1, 0, 0, '{10'b110100_1110, 1, 0, 1});
    step("D11.7p", 8'hEB, 0, 1, 0, 0, '{10'b110100_1000, 1, 0, 0});
    step("K23.7", 8'hF7, 1, 1, 0, 0, '{10'b111010_1000, 1, 0, 0});
    step("D7.3p", 8'h67, 0, 1, 1, 1, '{10'b000111_0011, 1, 0, 1});

    @(negedge pclk);
    d2 = 16'h0303; k2 = 2'b00; v2 = 1'b1;
    @(posedge pclk);
    #1;
    chk("L2.sym", e2, {10'b110001_0100, 10'b110001_1011});
    chk("L2.rd", ro2, 0);
    chk("L2.err", ce2, 0);
    @(negedge pclk);
    d2 = 16'h00BC; k2 = 2'b11;
    @(posedge pclk);
    #1;
    chk("L2k.sym", e2, {10'b110000_0101, 10'b001111_1010});
    chk("L2k.err", ce2, 2'b10);
    chk("L2k.rd", ro2, 0);

    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 256; b++) begin
        drive(b[7:0], 0, 1, 1, r[0]);
        seen[r][b] = e1;
        chk($sformatf("Dsw%0d_%02h.err", r, b), ce1, 0);
        check_disp($sformatf("Dsw%0d_%02h", r, b), r[0]);
      end
    for (int r = 0; r < 2; r++) begin
      dups = 0;
      for (int i = 0; i < 256; i++)
        for (int j = i + 1; j < 256; j++)
          if (seen[r][i] == seen[r][j]) dups++;
      chk($sformatf("uniq%0d", r), dups, 0);
    end

    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 256; b++) begin
        legal = (b[4:0] == 5'd28) || (b == 'hF7) || (b == 'hFB) || (b == 'hFD) || (b == 'hFE);
        drive(b[7:0], 1, 1, 1, r[0]);
        chk($sformatf("Ksw%0d_%02h.err", r, b), ce1, !legal);
        if (legal) check_disp($sformatf("Ksw%0d_%02h", r, b), r[0]);
        else chk($sformatf("Ksw%0d_%02h.sub", r, b), e1, r[0] ? 10'b110000_0101 : 10'b001111_1010);
      end

    @(negedge pclk);
    d1 = 8'h03; k1 = 0; v1 = 1; rs1 = 1; rv1 = 1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst.sym", e1, 0);
    chk("arst.vld", ev1, 0);
    chk("arst.rd", ro1, 0);
    chk("arst.err", ce1, 0);
    chk("arst.sym2", e2, 0);
    chk("arst.vld2", ev2, 0);
    repeat (2) @(negedge pclk);
    rst = 1'b1; v1 = 0; rs1 = 0;
    step("post", 8'h00, 0, 1, 0, 0, '{10'b100111_0100, 1, 0, 0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
